// File: rtl/wbus_arbiter.sv
// Round-robin owner arbiter for the shared 8-bit W bus: grants one registered tri-state
// enable at a time, inserts a dead cycle between owners and caps hold time under contention.
module wbus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] EN,
    output logic             BUSY,
    output logic [IDX_W-1:0] OWNER,
    output logic             TIMEOUT
);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic [2*N_REQ-1:0] reqDbl;
    logic [N_REQ-1:0]   reqRot;
    logic [IDX_W-1:0]   rotOff;
    logic [IDX_W:0]     winSum;
    logic [IDX_W-1:0]   winIdx;
    logic               winValid;
    logic [N_REQ-1:0]   ownerMask;
    logic               ownerReq;
    logic               othersReq;
    logic [IDX_W-1:0]   ownerNext;

    // Rotate REQ so the round-robin pointer lands on bit 0, then take the lowest set bit.
    always_comb begin
        reqDbl   = {REQ, REQ};
        reqRot   = N_REQ'(reqDbl >> ptr_q);
        rotOff   = '0;
        winValid = 1'b0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (reqRot[j]) begin
                winValid = 1'b1;
                rotOff   = IDX_W'(j);
            end
        end
        winSum = (IDX_W+1)'(ptr_q) + (IDX_W+1)'(rotOff);
        winIdx = (winSum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(winSum - (IDX_W+1)'(N_REQ))
                                               : IDX_W'(winSum);
    end

    always_comb begin
        ownerMask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ownerMask[i] = (owner_q == IDX_W'(i));
        end
        ownerReq  = |(REQ & ownerMask);
        othersReq = |(REQ & ~ownerMask);
        ownerNext = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    end

    // A voluntary drop takes priority over hold expiry, so that case never raises TIMEOUT.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (winValid) begin
                    state_d = OWN;
                    owner_d = winIdx;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!ownerReq) begin
                    ptr_d   = ownerNext;
                    cnt_d   = '0;
                    state_d = othersReq ? TURN : IDLE;
                end else if (cnt_q == CNT_W'(MAX_HOLD) && othersReq) begin
                    ptr_d     = ownerNext;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = TURN;
                end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign EN      = (state_q == OWN) ? ownerMask : '0;
    assign BUSY    = (state_q == OWN);
    assign OWNER   = owner_q;
    assign TIMEOUT = timeout_q;

endmodule
